dds_phase_gen: RTL and testbench

Parametrised, runtime-programmable DDS phase accumulator and ROM address generator with linear frequency sweep (chirp). It feeds the waveform ROM address port in the signal-generation path, replacing fixed compile-time frequency and phase words with shadowed configuration registers. It also provides a one-shot or bounce frequency sweep, a phase-wrap strobe for downstream framing, and synchronous phase reset.

---
 rtl/dds_phase_gen.sv | 228 ++++++++++++++++++++++
 tb/tb_dds_phase_gen.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dds_phase_gen.sv
// dds_phase_gen: runtime-programmable DDS phase accumulator and waveform ROM
// address generator with shadowed configuration and linear frequency sweep.
//
// Ports:
//   clk         system clock
//   rst_n       asynchronous active-low reset
//   en          accumulator / sweep advance enable
//   phase_rst   synchronous accumulator clear (wins over en)
//   cfg_we      shadow register write strobe
//   cfg_sel     shadow select: 0 F_START, 1 F_STOP, 2 F_STEP, 3 PWORD
//   cfg_data    shadow write data (PWORD uses the low ADDR_W bits)
//   commit      copy shadows to the active set and restart the sweep
//   sweep_en    1 = sweep, 0 = fixed frequency at F_START
//   sweep_mode  0 = one-shot, 1 = bounce between start and stop
//   addr_out    registered ROM address (accumulator MSBs + phase offset)
//   wrap        one-cycle pulse on accumulator carry-out
//   fword_cur   active frequency word
//   sweep_done  one-shot sweep has reached F_STOP (level)
module dds_phase_gen #(
   parameter int unsigned ACC_W     = 32,
   parameter int unsigned ADDR_W    = 8,
   parameter int unsigned FWORD_RST = 429497,
   parameter int unsigned PWORD_RST = 128,
   parameter int unsigned SWEEP_DIV = 1000
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en,
   input  logic              phase_rst,
   input  logic              cfg_we,
   input  logic [1:0]        cfg_sel,
   input  logic [ACC_W-1:0]  cfg_data,
   input  logic              commit,
   input  logic              sweep_en,
   input  logic              sweep_mode,
   output logic [ADDR_W-1:0] addr_out,
   output logic              wrap,
   output logic [ACC_W-1:0]  fword_cur,
   output logic              sweep_done
);

   localparam int unsigned CNT_W = (SWEEP_DIV > 1) ? $clog2(SWEEP_DIV) : 1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SWEEP = 2'd1,
      S_HOLD  = 2'd2
   } state_t;

   // shadow and active configuration
   logic [ACC_W-1:0]  r_sh_start, r_sh_stop, r_sh_step;
   logic [ADDR_W-1:0] r_sh_pword;
   logic [ACC_W-1:0]  r_start, r_stop, r_step;
   logic [ADDR_W-1:0] r_pword;

   // accumulator path
   logic [ACC_W-1:0]  r_acc;
   logic [ADDR_W-1:0] r_addr;
   logic              r_wrap;
   logic [ACC_W:0]    w_sum;

   // sweep FSM
   state_t            r_state, w_state_nxt;
   logic [ACC_W-1:0]  r_fword, w_fword_nxt;
   logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
   logic              r_done, w_done_nxt;
   logic              r_dir_up, w_dir_nxt;
   logic [ACC_W-1:0]  r_target, w_tgt_nxt;
   logic [ACC_W-1:0]  w_step_fw;
   logic              w_hit;
   logic              w_tick;

   assign addr_out   = r_addr;
   assign wrap       = r_wrap;
   assign fword_cur  = r_fword;
   assign sweep_done = r_done;

   // Shadow writes and commit; commit samples pre-edge shadows.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sh_start <= ACC_W'(FWORD_RST);
         r_sh_stop  <= ACC_W'(FWORD_RST);
         r_sh_step  <= '0;
         r_sh_pword <= ADDR_W'(PWORD_RST);
         r_start    <= ACC_W'(FWORD_RST);
         r_stop     <= ACC_W'(FWORD_RST);
         r_step     <= '0;
         r_pword    <= ADDR_W'(PWORD_RST);
      end else begin
         if (cfg_we) begin
            case (cfg_sel)
               2'd0:    r_sh_start <= cfg_data;
               2'd1:    r_sh_stop  <= cfg_data;
               2'd2:    r_sh_step  <= cfg_data;
               default: r_sh_pword <= cfg_data[ADDR_W-1:0];
            endcase
         end
         if (commit) begin
            r_start <= r_sh_start;
            r_stop  <= r_sh_stop;
            r_step  <= r_sh_step;
            r_pword <= r_sh_pword;
         end
      end
   end

   assign w_sum = {1'b0, r_acc} + {1'b0, r_fword};

   // Phase accumulator; address is formed from the pre-edge accumulator.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_acc  <= '0;
         r_addr <= '0;
         r_wrap <= 1'b0;
      end else if (phase_rst) begin
         r_acc  <= '0;
         r_addr <= r_pword;
         r_wrap <= 1'b0;
      end else if (en) begin
         r_acc  <= w_sum[ACC_W-1:0];
         r_wrap <= w_sum[ACC_W];
         r_addr <= r_acc[ACC_W-1 -: ADDR_W] + r_pword;
      end else begin
         r_wrap <= 1'b0;
      end
   end

   assign w_tick = (r_cnt == CNT_W'(SWEEP_DIV - 1));

   // Sweep FSM state and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= S_IDLE;
         r_fword  <= ACC_W'(FWORD_RST);
         r_cnt    <= '0;
         r_done   <= 1'b0;
         r_dir_up <= 1'b1;
         r_target <= ACC_W'(FWORD_RST);
      end else begin
         r_state  <= w_state_nxt;
         r_fword  <= w_fword_nxt;
         r_cnt    <= w_cnt_nxt;
         r_done   <= w_done_nxt;
         r_dir_up <= w_dir_nxt;
         r_target <= w_tgt_nxt;
      end
   end

   // Next state / outputs; the step clamps to the target without wrapping.
   always_comb begin
      w_state_nxt = r_state;
      w_fword_nxt = r_fword;
      w_cnt_nxt   = r_cnt;
      w_done_nxt  = r_done;
      w_dir_nxt   = r_dir_up;
      w_tgt_nxt   = r_target;
      w_step_fw   = r_fword;
      w_hit       = 1'b0;

      // fword never passes the target, so these differences cannot underflow
      if (r_dir_up) begin
         if ((r_target - r_fword) <= r_step) begin
            w_step_fw = r_target;
            w_hit     = 1'b1;
         end else begin
            w_step_fw = r_fword + r_step;
         end
      end else begin
         if ((r_fword - r_target) <= r_step) begin
            w_step_fw = r_target;
            w_hit     = 1'b1;
         end else begin
            w_step_fw = r_fword - r_step;
         end
      end

      if (commit) begin
         w_state_nxt = S_IDLE;
         w_fword_nxt = r_sh_start;
         w_cnt_nxt   = '0;
         w_done_nxt  = 1'b0;
      end else if (!sweep_en) begin
         w_state_nxt = S_IDLE;
         w_fword_nxt = r_start;
         w_cnt_nxt   = '0;
         w_done_nxt  = 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               w_fword_nxt = r_start;
               w_cnt_nxt   = '0;
               if ((r_step != '0) && (r_start != r_stop)) begin
                  w_state_nxt = S_SWEEP;
                  w_dir_nxt   = (r_stop >= r_start);
                  w_tgt_nxt   = r_stop;
               end
            end
            S_SWEEP: begin
               if (en) begin
                  if (w_tick) begin
                     w_cnt_nxt   = '0;
                     w_fword_nxt = w_step_fw;
                     if (w_hit) begin
                        if (!sweep_mode) begin
                           w_state_nxt = S_HOLD;
                           w_done_nxt  = 1'b1;
                        end else begin
                           // bounce: head back toward the other endpoint
                           w_dir_nxt = ~r_dir_up;
                           w_tgt_nxt = (r_target == r_stop) ? r_start : r_stop;
                        end
                     end
                  end else begin
                     w_cnt_nxt = r_cnt + CNT_W'(1);
                  end
               end
            end
            S_HOLD: begin
               w_fword_nxt = r_stop;
            end
            default: begin
               w_state_nxt = S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dds_phase_gen.sv
// Directed bench for dds_phase_gen with a scoreboard of expected outputs.
module tb_dds_phase_gen;

   localparam int unsigned F_ADDR = 0;
   localparam int unsigned F_WRAP = 1;
   localparam int unsigned F_FW   = 2;
   localparam int unsigned F_DONE = 3;

   logic        clk;
   logic        rst_n;
   logic        en;
   logic        phase_rst;
   logic        cfg_we;
   logic [1:0]  cfg_sel;
   logic [31:0] cfg_data;
   logic        commit;
   logic        sweep_en;
   logic        sweep_mode;
   logic [7:0]  addr_out;
   logic        wrap;
   logic [31:0] fword_cur;
   logic        sweep_done;

   typedef struct {
      string       tag;
      int unsigned fld;
      logic [31:0] val;
   } exp_t;

   exp_t sb[$];
   int   n_cmp;
   int   n_bad;
   string cur_tag;

   // reference model state
   logic [31:0] m_acc;
   logic [31:0] m_fw;
   logic [7:0]  m_pw;
   logic [7:0]  m_addr;
   logic        m_done;

   dds_phase_gen #(
      .ACC_W     (32),
      .ADDR_W    (8),
      .FWORD_RST (429497),
      .PWORD_RST (128),
      .SWEEP_DIV (4)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .en         (en),
      .phase_rst  (phase_rst),
      .cfg_we     (cfg_we),
      .cfg_sel    (cfg_sel),
      .cfg_data   (cfg_data),
      .commit     (commit),
      .sweep_en   (sweep_en),
      .sweep_mode (sweep_mode),
      .addr_out   (addr_out),
      .wrap       (wrap),
      .fword_cur  (fword_cur),
      .sweep_done (sweep_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: observed no finish, expected finish before 1 ms");
      $fatal(1, "watchdog expired");
   end

   function automatic logic [31:0] observe(input int unsigned f);
      case (f)
         F_ADDR:  return 32'(addr_out);
         F_WRAP:  return 32'(wrap);
         F_FW:    return fword_cur;
         default: return 32'(sweep_done);
      endcase
   endfunction

   task automatic expect_val(input string tag, input int unsigned f, input logic [31:0] v);
      exp_t e;
      e.tag = tag;
      e.fld = f;
      e.val = v;
      sb.push_back(e);
   endtask

   task automatic check_all();
      exp_t        e;
      logic [31:0] obs;
      while (sb.size() > 0) begin
         e   = sb.pop_front();
         obs = observe(e.fld);
         n_cmp++;
         assert (obs === e.val) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.val);
         end
      end
   endtask

   // one clock with en/phase_rst; predicts all four outputs after the edge
   task automatic cyc(input logic e, input logic pr, input logic [31:0] fw_nxt,
                      input logic done_nxt, input logic [7:0] pw_nxt);
      logic [32:0] s;
      logic        exp_wrap;
      logic [7:0]  exp_addr;
      en        = e;
      phase_rst = pr;
      exp_addr  = m_addr;
      exp_wrap  = 1'b0;
      if (pr) begin
         m_acc    = '0;
         exp_addr = m_pw;
      end else if (e) begin
         exp_addr = m_acc[31:24] + m_pw;
         s        = {1'b0, m_acc} + {1'b0, m_fw};
         m_acc    = s[31:0];
         exp_wrap = s[32];
      end
      expect_val({cur_tag, ".addr"}, F_ADDR, 32'(exp_addr));
      expect_val({cur_tag, ".wrap"}, F_WRAP, 32'(exp_wrap));
      expect_val({cur_tag, ".fword"}, F_FW, fw_nxt);
      expect_val({cur_tag, ".done"}, F_DONE, 32'(done_nxt));
      @(posedge clk);
      #1;
      check_all();
      m_addr = exp_addr;
      m_fw   = fw_nxt;
      m_pw   = pw_nxt;
      m_done = done_nxt;
   endtask

   task automatic run(input logic e, input logic pr);
      cyc(e, pr, m_fw, m_done, m_pw);
   endtask

   task automatic cfg_write(input logic [1:0] sel, input logic [31:0] d);
      cfg_we   = 1'b1;
      cfg_sel  = sel;
      cfg_data = d;
      run(1'b0, 1'b0);
      cfg_we   = 1'b0;
   endtask

   task automatic do_commit(input logic [31:0] fw, input logic [7:0] pw);
      commit = 1'b1;
      cyc(1'b0, 1'b0, fw, 1'b0, pw);
      commit = 1'b0;
   endtask

   task automatic model_reset();
      m_acc  = '0;
      m_fw   = 32'd429497;
      m_pw   = 8'd128;
      m_addr = '0;
      m_done = 1'b0;
   endtask

   initial begin
      int unsigned bounce_tbl [6];
      logic [31:0] fw;
      bounce_tbl = '{130, 110, 100, 120, 130, 110};
      n_cmp = 0;
      n_bad = 0;
      rst_n = 1'b0;
      en = 1'b0; phase_rst = 1'b0; cfg_we = 1'b0; cfg_sel = 2'd0;
      cfg_data = '0; commit = 1'b0; sweep_en = 1'b0; sweep_mode = 1'b0;
      model_reset();

      // reset state
      repeat (2) @(posedge clk);
      #1;
      cur_tag = "reset";
      expect_val("reset.addr", F_ADDR, 32'd0);
      expect_val("reset.wrap", F_WRAP, 32'd0);
      expect_val("reset.fword", F_FW, 32'd429497);
      expect_val("reset.done", F_DONE, 32'd0);
      check_all();
      rst_n = 1'b1;

      // default frequency, free running through the first carry
      cur_tag = "default";
      for (int n = 1; n <= 10002; n++) begin
         if (n == 1) expect_val("default.first_addr", F_ADDR, 32'd128);
         if (n == 9999) expect_val("default.no_wrap_9999", F_WRAP, 32'd0);
         if (n == 10000) expect_val("default.wrap_10000", F_WRAP, 32'd1);
         run(1'b1, 1'b0);
      end

      // shadow writes do not disturb the active set
      cur_tag = "shadow";
      cfg_write(2'd0, 32'h0100_0000);
      cfg_write(2'd3, 32'd0);
      cur_tag = "commit_ramp";
      do_commit(32'h0100_0000, 8'd0);

      // phase_rst together with en clears the phase
      cur_tag = "prst_en";
      expect_val("prst_en.addr_pword", F_ADDR, 32'd0);
      run(1'b1, 1'b1);

      // address ramp 0..255,0 with one wrap per 256 cycles
      cur_tag = "ramp";
      for (int k = 1; k <= 258; k++) begin
         expect_val("ramp.const_addr", F_ADDR, 32'((k - 1) % 256));
         expect_val("ramp.const_wrap", F_WRAP, (k == 256) ? 32'd1 : 32'd0);
         run(1'b1, 1'b0);
      end

      // en low freezes everything
      cur_tag = "freeze";
      repeat (5) run(1'b0, 1'b0);

      // commit with a concurrent start write takes the old shadow value
      cur_tag = "commit_race";
      cfg_write(2'd0, 32'h0200_0000);
      cfg_we   = 1'b1;
      cfg_sel  = 2'd0;
      cfg_data = 32'h0300_0000;
      do_commit(32'h0200_0000, 8'd0);
      cfg_we   = 1'b0;
      do_commit(32'h0300_0000, 8'd0);

      // one-shot sweep 100 -> 130 by 10
      cur_tag = "oneshot";
      cfg_write(2'd0, 32'd100);
      cfg_write(2'd1, 32'd130);
      cfg_write(2'd2, 32'd10);
      do_commit(32'd100, 8'd0);
      sweep_en   = 1'b1;
      sweep_mode = 1'b0;
      for (int k = 1; k <= 16; k++) begin
         fw = (k < 5) ? 32'd100 : (k < 9) ? 32'd110 : (k < 13) ? 32'd120 : 32'd130;
         cyc(1'b1, 1'b0, fw, (k >= 13), 8'd0);
      end
      cur_tag = "oneshot_off";
      sweep_en = 1'b0;
      cyc(1'b1, 1'b0, 32'd100, 1'b0, 8'd0);

      // bounce sweep 130 <-> 100 by 20
      cur_tag = "bounce";
      cfg_write(2'd0, 32'd130);
      cfg_write(2'd1, 32'd100);
      cfg_write(2'd2, 32'd20);
      do_commit(32'd130, 8'd0);
      sweep_en   = 1'b1;
      sweep_mode = 1'b1;
      for (int k = 1; k <= 24; k++) begin
         cyc(1'b1, 1'b0, 32'(bounce_tbl[(k - 1) / 4]), 1'b0, 8'd0);
      end
      cur_tag = "bounce_freeze";
      repeat (5) cyc(1'b0, 1'b0, 32'd110, 1'b0, 8'd0);
      cur_tag = "bounce_resume";
      cyc(1'b1, 1'b0, 32'd100, 1'b0, 8'd0);
      cur_tag = "bounce_drop";
      sweep_en = 1'b0;
      cyc(1'b1, 1'b0, 32'd130, 1'b0, 8'd0);
      sweep_mode = 1'b0;

      // zero frequency word: phase frozen, no wrap
      cur_tag = "fw_zero";
      cfg_write(2'd0, 32'd0);
      cfg_write(2'd3, 32'd5);
      do_commit(32'd0, 8'd5);
      run(1'b1, 1'b1);
      for (int k = 0; k < 4; k++) begin
         expect_val("fw_zero.const_addr", F_ADDR, 32'd5);
         expect_val("fw_zero.const_wrap", F_WRAP, 32'd0);
         run(1'b1, 1'b0);
      end

      // asynchronous reset mid-operation, shadows lost
      en = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      expect_val("async_rst.addr", F_ADDR, 32'd0);
      expect_val("async_rst.wrap", F_WRAP, 32'd0);
      expect_val("async_rst.fword", F_FW, 32'd429497);
      expect_val("async_rst.done", F_DONE, 32'd0);
      check_all();
      model_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      cur_tag = "post_rst_commit";
      do_commit(32'd429497, 8'd128);
      cur_tag = "post_rst_run";
      expect_val("post_rst_run.const_addr", F_ADDR, 32'd128);
      run(1'b1, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
